// File: rtl/ddr_word_align_if.sv
// Handshake/bus bundle between the DDR init sequencer and the word-align
// trainer. The trainer uses the slave modport; the sequencer (or a bench)
// uses master.
interface ddr_word_align_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] DATA;
  logic             ALIGNWD;
  logic             DONE;
  logic             FAIL;
  logic [3:0]       SLIP_CNT;

  modport master (
    output START, DATA,
    input  ALIGNWD, DONE, FAIL, SLIP_CNT
  );

  modport slave (
    input  START, DATA,
    output ALIGNWD, DONE, FAIL, SLIP_CNT
  );
endinterface

// File: rtl/ddr_word_align.sv
// Word-alignment training controller for the DDR gearing path.
// Issues ALIGNWD slip pulses until DATA shows PATTERN for MATCH_CNT
// consecutive words, then reports DONE; reports FAIL once MAX_SLIPS slips
// have been spent without lock.
// Optional: define DDR_ALIGN_MONITOR_EN to keep watching DATA while locked
// and retrain automatically after 4 consecutive mismatching words.
module ddr_word_align #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PATTERN   = 'hB4,
  parameter int               SETTLE    = 8,
  parameter int               MATCH_CNT = 4,
  parameter int               PULSE_W   = 1,
  parameter int               MAX_SLIPS = 8
) (
  input  logic              CLKI,
  input  logic              RSTN,
  ddr_word_align_if.slave   bus
);

  localparam logic [7:0] SETTLE_V = 8'(SETTLE);
  localparam logic [3:0] MATCH_LAST = 4'(MATCH_CNT - 1);
  localparam logic [2:0] PULSE_V = 3'(PULSE_W);
  localparam logic [3:0] MAX_SLIPS_V = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAILED
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [3:0] match_q, match_d;
  logic [2:0] pulse_q, pulse_d;
  logic [3:0] slip_q, slip_d;
  logic       align_q, align_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  logic       is_match;
`ifdef DDR_ALIGN_MONITOR_EN
  logic [1:0] miss_q, miss_d;
`endif

  assign is_match = (bus.DATA == PATTERN);

  // Next-state and registered-output logic for the training FSM.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    pulse_d  = pulse_q;
    slip_d   = slip_q;
    align_d  = align_q;
    done_d   = done_q;
    fail_d   = fail_q;
`ifdef DDR_ALIGN_MONITOR_EN
    miss_d   = miss_q;
`endif
    case (state_q)
      S_IDLE, S_LOCKED, S_FAILED: begin
        if (bus.START) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_V;
          slip_d   = '0;
          done_d   = 1'b0;
          fail_d   = 1'b0;
`ifdef DDR_ALIGN_MONITOR_EN
          miss_d   = '0;
`endif
        end
`ifdef DDR_ALIGN_MONITOR_EN
        else if (state_q == S_LOCKED) begin
          // Lost lock after four bad words in a row: retrain from scratch.
          if (is_match) begin
            miss_d = '0;
          end else if (miss_q == 2'd3) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_V;
            slip_d   = '0;
            done_d   = 1'b0;
            miss_d   = '0;
          end else begin
            miss_d = miss_q + 2'd1;
          end
        end
`endif
      end
      S_SETTLE: begin
        // settle_q counts the remaining cycles; the last one moves to CHECK.
        if (settle_q <= 8'd1) begin
          state_d = S_CHECK;
          match_d = '0;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (is_match) begin
          if (match_q == MATCH_LAST) begin
            state_d = S_LOCKED;
            done_d  = 1'b1;
            match_d = '0;
          end else begin
            match_d = match_q + 4'd1;
          end
        end else if (slip_q < MAX_SLIPS_V) begin
          state_d = S_SLIP;
          align_d = 1'b1;
          slip_d  = slip_q + 4'd1;
          pulse_d = PULSE_V;
        end else begin
          state_d = S_FAILED;
          fail_d  = 1'b1;
        end
      end
      S_SLIP: begin
        if (pulse_q <= 3'd1) begin
          state_d  = S_SETTLE;
          align_d  = 1'b0;
          settle_d = SETTLE_V;
        end else begin
          pulse_d = pulse_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLKI) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      match_q  <= '0;
      pulse_q  <= '0;
      slip_q   <= '0;
      align_q  <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
`ifdef DDR_ALIGN_MONITOR_EN
      miss_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      pulse_q  <= pulse_d;
      slip_q   <= slip_d;
      align_q  <= align_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
`ifdef DDR_ALIGN_MONITOR_EN
      miss_q   <= miss_d;
`endif
    end
  end

  assign bus.ALIGNWD  = align_q;
  assign bus.DONE     = done_q;
  assign bus.FAIL     = fail_q;
  assign bus.SLIP_CNT = slip_q;

endmodule

// File: doc/ddr_word_align.md
# ddr_word_align

Word-alignment training controller for the DDR gearing path. It drives the `ALIGNWD` slip input of the clock divider and the gearbox, watches the deserialized parallel word for a known training pattern, and issues slip pulses until the pattern is received at the correct word boundary. It runs in the divided (CDIVX/SCLK) domain and reports lock or failure to the DDR3 init sequencer.

## Interface
- `WIDTH`, 8: parallel word width from the input gearbox (x4 gearing).
- `PATTERN`, 8'hB4: expected training word, compared over all `WIDTH` bits.
- `SETTLE`, 8: wait cycles after start and after each slip before comparing. Range 1..255.
- `MATCH_CNT`, 4: consecutive matching words required for lock. Range 1..15.
- `PULSE_W`, 1: `ALIGNWD` high time in CLKI cycles. Range 1..7.
- `MAX_SLIPS`, 8: slips allowed before failure. Range 1..15.
- `CLKI`  in  1  divided system clock (CDIVX); all logic is on the rising edge.
- `RSTN`  in  1  synchronous, active-low reset.
- `START`  in  1  level request to (re)start training.
- `DATA`  in  WIDTH  deserialized word, valid every cycle.
- `ALIGNWD`  out  1  slip pulse to the divider/gearbox.
- `DONE`  out  1  aligned; held until restart or reset.
- `FAIL`  out  1  `MAX_SLIPS` exhausted without lock; held until restart or reset.
- `SLIP_CNT`  out  4  slips issued since last start.

## Operation
- All outputs are registered. Reset (`RSTN`=0 at an edge): state IDLE, `ALIGNWD`=0, `DONE`=0, `FAIL`=0, `SLIP_CNT`=0, internal counters 0.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAILED.
- IDLE/LOCKED/FAILED with `START`=1 → SETTLE. `SLIP_CNT`, `DONE` and `FAIL` clear on the same edge, and the settle counter loads `SETTLE`. `START` is ignored in SETTLE, CHECK and SLIP.
- SETTLE: counts down one per cycle. After `SETTLE` cycles in the state → CHECK with the match counter at 0.
- CHECK: compares `DATA` with `PATTERN` each cycle.
  - Match: increment the match counter. On the `MATCH_CNT`-th consecutive match → LOCKED and `DONE`=1 on that edge.
  - Mismatch with `SLIP_CNT` < `MAX_SLIPS` → SLIP. On that edge `ALIGNWD`=1 and `SLIP_CNT` increments.
  - Mismatch with `SLIP_CNT` = `MAX_SLIPS` → FAILED and `FAIL`=1.
- SLIP: `ALIGNWD` stays high for exactly `PULSE_W` cycles, then → SETTLE with `ALIGNWD`=0 and the settle counter reloaded.
- LOCKED and FAILED hold until `START` or reset.
- `SLIP_CNT` saturates at `MAX_SLIPS` and never wraps. `DONE` and `FAIL` are never high together.

## Timing
- `START` sampled at edge k (idle) → `DONE` rises at edge k+`SETTLE`+`MATCH_CNT` when aligned on the first try. With defaults that is k+12.
- Each slip adds `PULSE_W`+`SETTLE`+(cycles spent in CHECK before the mismatch).
- `ALIGNWD` rises on the edge that first detects a mismatch: one cycle after the bad `DATA` is presented.
- Worst-case `FAIL`: after `MAX_SLIPS`+1 SETTLE/CHECK rounds.
- `RSTN` low in any state, including mid-pulse, forces the reset values at the next edge. `ALIGNWD` drops on that edge.
- `START` high continuously from LOCKED/FAILED restarts training once per completion. The bench must deassert it.

## Configuration
- `DDR_ALIGN_MONITOR_EN` defined: LOCKED keeps comparing `DATA`. After 4 consecutive mismatches the block drops `DONE`, clears `SLIP_CNT` and goes to SETTLE, retraining without `START`. Any match resets the mismatch count.
- Not defined: LOCKED ignores `DATA`, and `DONE` is sticky until `START` or reset.

## Test plan
- Reset: hold `RSTN`=0 for 3 cycles with `START`=1 → all outputs 0, state IDLE; after release, training starts on the next edge.
- Aligned at once: `DATA`=8'hB4 constant, `START` pulse at edge 0 → `DONE`=1 at edge 12, `SLIP_CNT`=0, `ALIGNWD` never high.
- Two slips: the bench model rotates `DATA` by one bit per `ALIGNWD` pulse and starts 2 positions off → exactly 2 one-cycle `ALIGNWD` pulses, `SLIP_CNT`=2, then `DONE`=1.
- Failure: `DATA`=8'h00 constant → 8 pulses, then `FAIL`=1 with `SLIP_CNT`=8 and `DONE`=0. `START` again clears `FAIL` on the next edge.
- Broken run: 3 matches, 1 mismatch, then pattern → exactly one slip, match counter restarts, and `DONE` comes only after 4 new consecutive matches.
- Monitor (`DDR_ALIGN_MONITOR_EN`): after lock, drive 4 words of 8'h5A → `DONE` falls on the 4th edge and retraining starts. Without the macro, `DONE` stays 1.
